instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Upstream feeder of the multicycle MIPS control FSM.
- Owns the PC and the instruction register (IR).
- Runs a request/grant/read-valid handshake to instruction memory with variable wait states.
- Splits the latched instruction into the fields the control FSM and datapath consume: op_code, funct, register indices, shamt, immediate.
- Applies the PC updates requested by the control FSM: PCWrite, PCWriteCond and PCSource.

Parameters:
- N, 32: datapath/PC/instruction width.
- RESET_PC, 32'h0000_0000: PC value after reset.
- TIMEOUT, 16: max cycles in WAIT before fetch error; valid range 2..255.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- ir_write  in  1  fetch-start pulse (control IRWrite).
- pc_write  in  1  unconditional PC write (PCWrite).
- pc_write_cond  in  1  branch PC write, qualified by alu_zero (PCWriteCond).
- alu_zero  in  1  ALU zero flag.
- pc_source  in  2  PC next select: 00 alu_result, 01 alu_out, 10 jump target, 11 hold.
- alu_result  in  N  combinational ALU output (PC+4 path).
- alu_out  in  N  registered ALU output (branch target).
- mem_req  out  1  instruction memory request.
- mem_addr  out  N  request address.
- mem_gnt  in  1  memory accepted request.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  N  read data.
- pc  out  N  current PC.
- instr  out  N  IR contents.
- op_code  out  6  instr[31:26].
- funct  out  6  instr[5:0].
- rs, rt, rd, shamt  out  5 each  instr[25:21], [20:16], [15:11], [10:6].
- imm  out  16  instr[15:0].
- fetch_busy  out  1  high in REQ or WAIT.
- instr_valid  out  1  one-cycle pulse when IR is updated.
- fetch_err  out  1  sticky error flag.

Behaviour:
- Reset values:
  - pc = RESET_PC; instr = 0, so all fields are 0.
  - mem_req = 0, mem_addr = 0, fetch_busy = 0, instr_valid = 0, fetch_err = 0.
  - FSM = IDLE; timeout counter = 0.
- FSM states: IDLE, REQ, WAIT, ERR. Encoding goes in the shared package.
- IDLE:
  - ir_write=1 with pc[1:0]==0: latch fetch_addr=pc, go to REQ next cycle.
  - ir_write=1 with pc[1:0]!=0: go to ERR.
- REQ:
  - mem_req=1 and mem_addr=fetch_addr, held stable until mem_gnt.
  - mem_gnt=1: go to WAIT and clear the counter.
  - mem_rvalid in the same cycle as mem_gnt is treated as data: latch it and go to IDLE.
- WAIT:
  - mem_req=0; counter increments each cycle.
  - mem_rvalid=1: instr <= mem_rdata, instr_valid pulses for 1 cycle (the cycle after capture, IR already updated), go to IDLE.
  - Counter reaches TIMEOUT-1 without mem_rvalid: go to ERR.
- ERR:
  - fetch_err=1 and terminal; only rst exits.
  - PC updates still apply; ir_write is ignored.
- ir_write while fetch_busy=1: ignored. No queueing; IR and fetch_addr unchanged.
- Minimum latency, ir_write to instr_valid: 3 cycles with gnt and rvalid in consecutive cycles after REQ entry; 2 cycles if gnt and rvalid coincide.
- PC update, every cycle, independent of FSM state:
  - Write enable = pc_write | (pc_write_cond & alu_zero).
  - Next value: 00 alu_result; 01 alu_out; 10 {pc[31:28], instr[25:0], 2'b00} using the current IR; 11 no change even when enabled.
- Simultaneous ir_write and pc_write (normal FETCH cycle): fetch_addr captures the old pc and pc takes the new value. The fetch always uses the pre-update PC.
- mem_addr = fetch_addr in REQ; 0 otherwise.
- IR holds its value until the next successful capture; fields are pure slices of IR.
- Reset mid-fetch (REQ/WAIT): immediate return to IDLE with mem_req=0. A late mem_rvalid after reset is ignored because the FSM is in IDLE.
- Widths: counter is 8 bits. Arithmetic is unsigned; no PC increment inside the block (ALU provides it).

Decomposition:
- Shared package/defines file (alongside the existing opcode/funct defines):
  - FETCH FSM state encodings.
  - PCSource encodings (PCSRC_ALU=2'b00, PCSRC_ALUOUT=2'b01, PCSRC_JUMP=2'b10).
  - Instruction field bit positions.
- One natural sub-module: pc_next_mux. Combinational next-PC select plus write-enable qualification, reused later for a pipelined fetch.
- FSM, IR and fields stay in the top.

Test Plan:
1. Reset, then ir_write=1 with pc_write=1, pc_source=00, alu_result=0x4; mem_gnt next cycle, mem_rvalid with mem_rdata=0x012A4020 one cycle later → mem_addr=0x0 in REQ; pc=0x4; instr=0x012A4020; op_code=0, funct=0x20, rs=9, rt=10, rd=8; instr_valid pulses once.
2. Memory holds gnt low 3 cycles, then rvalid after 5 WAIT cycles (TIMEOUT=16) → mem_req high and mem_addr stable for all REQ cycles; fetch_busy high throughout; instr captured; no fetch_err.
3. gnt given, rvalid never asserted → fetch_err=1 exactly TIMEOUT cycles after WAIT entry; subsequent ir_write ignored; rst clears fetch_err and returns pc=RESET_PC.
4. Branch: pc_write_cond=1, alu_out=0x40: alu_zero=1 → pc=0x40; alu_zero=0 → pc unchanged. Jump: instr=0x08000010, pc=0x1000_0004, pc_source=10, pc_write=1 → pc=0x1000_0040.
5. Second ir_write during WAIT → ignored: no new request after completion, IR equals the first fetch's data. pc_source=11 with pc_write=1 → pc unchanged.
6. rst asserted mid-WAIT, then rvalid arrives → mem_req=0, FSM IDLE, instr stays 0, no instr_valid. Misaligned PC (pc=0x2 via alu_result) followed by ir_write → fetch_err=1 and no mem_req.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared encodings for the instruction fetch unit: fetch FSM states,
// PCSource selects and MIPS instruction field positions.
package instr_fetch_unit_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'b00,
        FETCH_REQ  = 2'b01,
        FETCH_WAIT = 2'b10,
        FETCH_ERR  = 2'b11
    } fetch_state_t;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_HOLD   = 2'b11;

    localparam int OP_HI    = 31;
    localparam int OP_LO    = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 11;
    localparam int SHAMT_HI = 10;
    localparam int SHAMT_LO = 6;
    localparam int FUNCT_HI = 5;
    localparam int FUNCT_LO = 0;
    localparam int IMM_HI   = 15;
    localparam int IMM_LO   = 0;
    localparam int JIDX_HI  = 25;
    localparam int JIDX_LO  = 0;

endpackage

// File: rtl/instr_fetch_unit_pc_next_mux.sv
// Next-PC select and write-enable qualification (PCWrite / PCWriteCond / PCSource).
module instr_fetch_unit_pc_next_mux
    import instr_fetch_unit_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] pc,
    input  logic [25:0]  jump_index,
    input  logic         pc_write,
    input  logic         pc_write_cond,
    input  logic         alu_zero,
    input  logic [1:0]   pc_source,
    input  logic [N-1:0] alu_result,
    input  logic [N-1:0] alu_out,
    output logic         pc_en,
    output logic [N-1:0] pc_next
);

    always_comb begin
        pc_en   = pc_write | (pc_write_cond & alu_zero);
        pc_next = pc;
        case (pc_source)
            PCSRC_ALU:    pc_next = alu_result;
            PCSRC_ALUOUT: pc_next = alu_out;
            PCSRC_JUMP:   pc_next = {pc[N-1:28], jump_index, 2'b00};
            default:      pc_en   = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns PC and IR, runs the req/gnt/rvalid fetch
// handshake and decodes IR fields for the multicycle control FSM.
//
// state      | meaning
// FETCH_IDLE | waiting for ir_write
// FETCH_REQ  | mem_req high, address held until mem_gnt
// FETCH_WAIT | granted, counting cycles until mem_rvalid or timeout
// FETCH_ERR  | misaligned fetch or timeout; sticky until rst
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int           N        = 32,
    parameter logic [N-1:0] RESET_PC = '0,
    parameter int           TIMEOUT  = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ir_write,
    input  logic         pc_write,
    input  logic         pc_write_cond,
    input  logic         alu_zero,
    input  logic [1:0]   pc_source,
    input  logic [N-1:0] alu_result,
    input  logic [N-1:0] alu_out,
    output logic         mem_req,
    output logic [N-1:0] mem_addr,
    input  logic         mem_gnt,
    input  logic         mem_rvalid,
    input  logic [N-1:0] mem_rdata,
    output logic [N-1:0] pc,
    output logic [N-1:0] instr,
    output logic [5:0]   op_code,
    output logic [5:0]   funct,
    output logic [4:0]   rs,
    output logic [4:0]   rt,
    output logic [4:0]   rd,
    output logic [4:0]   shamt,
    output logic [15:0]  imm,
    output logic         fetch_busy,
    output logic         instr_valid,
    output logic         fetch_err
);

    fetch_state_t state, state_nxt;
    logic [N-1:0] fetch_addr;
    logic [7:0]   wait_cnt;
    logic         capture;
    logic         latch_addr;
    logic         pc_en;
    logic [N-1:0] pc_next;

    instr_fetch_unit_pc_next_mux #(.N(N)) u_pc_next_mux (
        .pc            (pc),
        .jump_index    (instr[JIDX_HI:JIDX_LO]),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .alu_zero      (alu_zero),
        .pc_source     (pc_source),
        .alu_result    (alu_result),
        .alu_out       (alu_out),
        .pc_en         (pc_en),
        .pc_next       (pc_next)
    );

    always_comb begin
        state_nxt  = state;
        capture    = 1'b0;
        latch_addr = 1'b0;
        case (state)
            FETCH_IDLE: begin
                if (ir_write) begin
                    if (pc[1:0] == 2'b00) begin
                        state_nxt  = FETCH_REQ;
                        latch_addr = 1'b1;
                    end else begin
                        state_nxt = FETCH_ERR;
                    end
                end
            end
            FETCH_REQ: begin
                // Fast memories may return data in the grant cycle.
                if (mem_gnt) begin
                    if (mem_rvalid) begin
                        capture   = 1'b1;
                        state_nxt = FETCH_IDLE;
                    end else begin
                        state_nxt = FETCH_WAIT;
                    end
                end
            end
            FETCH_WAIT: begin
                if (mem_rvalid) begin
                    capture   = 1'b1;
                    state_nxt = FETCH_IDLE;
                end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
                    state_nxt = FETCH_ERR;
                end
            end
            default: state_nxt = FETCH_ERR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FETCH_IDLE;
            pc          <= RESET_PC;
            instr       <= '0;
            fetch_addr  <= '0;
            wait_cnt    <= '0;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            instr_valid <= capture;
            if (pc_en)
                pc <= pc_next;
            if (latch_addr)
                fetch_addr <= pc;
            if (capture)
                instr <= mem_rdata;
            if (state == FETCH_REQ && mem_gnt)
                wait_cnt <= '0;
            else if (state == FETCH_WAIT)
                wait_cnt <= wait_cnt + 8'd1;
        end
    end

    assign mem_req    = (state == FETCH_REQ);
    assign mem_addr   = mem_req ? fetch_addr : '0;
    assign fetch_busy = (state == FETCH_REQ) || (state == FETCH_WAIT);
    assign fetch_err  = (state == FETCH_ERR);

    assign op_code = instr[OP_HI:OP_LO];
    assign rs      = instr[RS_HI:RS_LO];
    assign rt      = instr[RT_HI:RT_LO];
    assign rd      = instr[RD_HI:RD_LO];
    assign shamt   = instr[SHAMT_HI:SHAMT_LO];
    assign funct   = instr[FUNCT_HI:FUNCT_LO];
    assign imm     = instr[IMM_HI:IMM_LO];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit against a cycle-level behavioural
// model of PC updates and the fetch handshake.
module tb_instr_fetch_unit;

    localparam int          N        = 32;
    localparam int          TIMEOUT  = 16;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        ir_write, pc_write, pc_write_cond, alu_zero;
    logic [1:0]  pc_source;
    logic [31:0] alu_result, alu_out;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic [31:0] pc, instr;
    logic [5:0]  op_code, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic        fetch_busy, instr_valid, fetch_err;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] m_pc, m_ir, m_addr;
    bit          m_valid, m_pending, m_granted, m_err;
    int          m_waited;

    always #5 clk = ~clk;

    instr_fetch_unit #(.N(N), .RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .ir_write(ir_write), .pc_write(pc_write),
        .pc_write_cond(pc_write_cond), .alu_zero(alu_zero), .pc_source(pc_source),
        .alu_result(alu_result), .alu_out(alu_out), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .pc(pc),
        .instr(instr), .op_code(op_code), .funct(funct), .rs(rs), .rt(rt), .rd(rd),
        .shamt(shamt), .imm(imm), .fetch_busy(fetch_busy), .instr_valid(instr_valid),
        .fetch_err(fetch_err)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    task automatic clear_inputs();
        ir_write = 0; pc_write = 0; pc_write_cond = 0; alu_zero = 0; pc_source = 2'b00;
        alu_result = 0; alu_out = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        m_pc = RESET_PC; m_ir = 0; m_addr = 0;
        m_valid = 0; m_pending = 0; m_granted = 0; m_err = 0; m_waited = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Advance one clock, updating the model from the inputs seen at the edge.
    task automatic tick();
        logic [31:0] npc;
        bit          cap;
        npc = m_pc;
        cap = 0;
        if (pc_write || (pc_write_cond && alu_zero)) begin
            if (pc_source == 2'b00)      npc = alu_result;
            else if (pc_source == 2'b01) npc = alu_out;
            else if (pc_source == 2'b10) npc = {m_pc[31:28], m_ir[25:0], 2'b00};
        end
        if (m_granted) begin
            if (mem_rvalid) cap = 1;
            else begin
                m_waited++;
                if (m_waited == TIMEOUT) begin
                    m_granted = 0;
                    m_err = 1;
                end
            end
        end else if (m_pending) begin
            if (mem_gnt) begin
                m_pending = 0;
                if (mem_rvalid) cap = 1;
                else begin
                    m_granted = 1;
                    m_waited = 0;
                end
            end
        end else if (!m_err && ir_write) begin
            if (m_pc[1:0] == 2'b00) begin
                m_pending = 1;
                m_addr = m_pc;
            end else m_err = 1;
        end
        if (cap) begin
            m_ir = mem_rdata;
            m_granted = 0;
        end
        m_valid = cap;
        m_pc = npc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (pc !== RESET_PC) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, RESET_PC); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", instr); end
        checks++; if ({op_code, rs, rt, rd, shamt, funct, imm} !== 48'h0) begin errors++; $display("FAIL reset_fields: got %h expected 0", {op_code, rs, rt, rd, shamt, funct, imm}); end
        checks++; if ({mem_req, fetch_busy, instr_valid, fetch_err} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {mem_req, fetch_busy, instr_valid, fetch_err}); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    endtask

    task automatic test_basic_fetch();
        ir_write = 1; pc_write = 1; pc_source = 2'b00; alu_result = 32'h4;
        tick();
        clear_inputs();
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL basic_req: got %b expected 1", mem_req); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL basic_addr: got %h expected 0", mem_addr); end
        checks++; if (pc !== 32'h4) begin errors++; $display("FAIL basic_pc: got %h expected 4", pc); end
        mem_gnt = 1;
        tick();
        clear_inputs();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b expected 0", instr_valid); end
        mem_rvalid = 1; mem_rdata = 32'h012A_4020;
        tick();
        clear_inputs();
        checks++; if (instr !== 32'h012A_4020) begin errors++; $display("FAIL basic_instr: got %h expected 012a4020", instr); end
        checks++; if ({op_code, funct} !== {6'd0, 6'h20}) begin errors++; $display("FAIL basic_op_funct: got %h/%h expected 0/20", op_code, funct); end
        checks++; if ({rs, rt, rd, shamt} !== {5'd9, 5'd10, 5'd8, 5'd0}) begin errors++; $display("FAIL basic_regs: got %0d %0d %0d %0d expected 9 10 8 0", rs, rt, rd, shamt); end
        checks++; if (imm !== 16'h4020) begin errors++; $display("FAIL basic_imm: got %h expected 4020", imm); end
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", instr_valid); end
        tick();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_pulse: got %b expected 0", instr_valid); end
    endtask

    task automatic test_wait_states();
        for (int it = 0; it < 8; it++) begin
            int          gnt_delay, wait_cycles;
            bit          coincide;
            logic [31:0] data;
            gnt_delay   = (it == 0) ? 3 : $urandom_range(0, 4);
            wait_cycles = (it == 0) ? 5 : (it == 1) ? TIMEOUT - 1 : $urandom_range(0, TIMEOUT - 2);
            coincide    = (it > 1) && ($urandom_range(0, 3) == 0);
            data        = $urandom();
            ir_write = 1; pc_write = 1; pc_source = 2'b00;
            alu_result = $urandom() & 32'hFFFF_FFFC;
            tick();
            clear_inputs();
            for (int c = 0; c <= gnt_delay; c++) begin
                checks++; if (mem_req !== 1'b1 || mem_addr !== m_addr) begin errors++; $display("FAIL ws_req it%0d: got req=%b addr=%h expected 1/%h", it, mem_req, mem_addr, m_addr); end
                checks++; if (fetch_busy !== 1'b1) begin errors++; $display("FAIL ws_busy_req it%0d: got %b expected 1", it, fetch_busy); end
                if (c < gnt_delay) tick();
            end
            mem_gnt = 1;
            if (coincide) begin mem_rvalid = 1; mem_rdata = data; end
            tick();
            clear_inputs();
            if (!coincide) begin
                for (int c = 0; c < wait_cycles; c++) begin
                    checks++; if (fetch_busy !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL ws_wait it%0d: got busy=%b req=%b expected 1/0", it, fetch_busy, mem_req); end
                    tick();
                end
                mem_rvalid = 1; mem_rdata = data;
                tick();
                clear_inputs();
            end
            checks++; if (instr !== data || instr !== m_ir) begin errors++; $display("FAIL ws_instr it%0d: got %h expected %h", it, instr, data); end
            checks++; if ({op_code, rs, rt, rd, shamt, funct} !== m_ir || imm !== m_ir[15:0]) begin errors++; $display("FAIL ws_fields it%0d: got %h expected %h", it, {op_code, rs, rt, rd, shamt, funct}, m_ir); end
            checks++; if (instr_valid !== m_valid || fetch_busy !== 1'b0 || fetch_err !== 1'b0) begin errors++; $display("FAIL ws_flags it%0d: got v=%b b=%b e=%b expected 1/0/0", it, instr_valid, fetch_busy, fetch_err); end
            checks++; if (pc !== m_pc) begin errors++; $display("FAIL ws_pc it%0d: got %h expected %h", it, pc, m_pc); end
            tick();
        end
    endtask

    task automatic test_timeout();
        int n;
        bit seen;
        ir_write = 1;
        tick();
        clear_inputs();
        mem_gnt = 1;
        tick();
        clear_inputs();
        n = 0;
        seen = 0;
        for (int c = 0; c < TIMEOUT + 4 && !seen; c++) begin
            tick();
            n++;
            if (fetch_err === 1'b1) seen = 1;
        end
        checks++; if (!seen || n != TIMEOUT) begin errors++; $display("FAIL timeout_cycles: got seen=%0d after %0d cycles expected %0d", seen, n, TIMEOUT); end
        checks++; if (fetch_err !== m_err) begin errors++; $display("FAIL timeout_model: got %b expected %b", fetch_err, m_err); end
        ir_write = 1;
        tick();
        clear_inputs();
        checks++; if ({mem_req, fetch_busy, fetch_err} !== 3'b001) begin errors++; $display("FAIL err_ignore_ir: got %b expected 001", {mem_req, fetch_busy, fetch_err}); end
        pc_write = 1; alu_result = $urandom();
        tick();
        clear_inputs();
        checks++; if (pc !== m_pc) begin errors++; $display("FAIL err_pc_update: got %h expected %h", pc, m_pc); end
        do_reset();
        checks++; if (fetch_err !== 1'b0 || pc !== RESET_PC) begin errors++; $display("FAIL err_reset: got err=%b pc=%h expected 0/%h", fetch_err, pc, RESET_PC); end
    endtask

    task automatic test_pc_update();
        pc_write = 1; alu_result = 32'h1000_0000;
        tick();
        clear_inputs();
        ir_write = 1; pc_write = 1; alu_result = 32'h1000_0004;
        tick();
        clear_inputs();
        checks++; if (mem_addr !== 32'h1000_0000) begin errors++; $display("FAIL pc_fetch_old: got %h expected 10000000", mem_addr); end
        mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'h0800_0010;
        tick();
        clear_inputs();
        checks++; if (instr_valid !== 1'b1 || instr !== 32'h0800_0010) begin errors++; $display("FAIL lat2: got v=%b instr=%h expected 1/08000010", instr_valid, instr); end
        pc_source = 2'b10; pc_write = 1;
        tick();
        clear_inputs();
        checks++; if (pc !== 32'h1000_0040 || pc !== m_pc) begin errors++; $display("FAIL jump: got %h expected 10000040", pc); end
        pc_write_cond = 1; pc_source = 2'b01; alu_out = 32'h40; alu_zero = 1;
        tick();
        checks++; if (pc !== 32'h40) begin errors++; $display("FAIL branch_taken: got %h expected 40", pc); end
        alu_zero = 0; alu_out = 32'h80;
        tick();
        clear_inputs();
        checks++; if (pc !== 32'h40) begin errors++; $display("FAIL branch_not_taken: got %h expected 40", pc); end
        for (int i = 0; i < 24; i++) begin
            pc_write = 1'($urandom_range(0, 1));
            pc_write_cond = 1'($urandom_range(0, 1));
            alu_zero = 1'($urandom_range(0, 1));
            pc_source = 2'($urandom_range(0, 3));
            alu_result = $urandom();
            alu_out = $urandom();
            tick();
            checks++; if (pc !== m_pc) begin errors++; $display("FAIL pc_random %0d: got %h expected %h", i, pc, m_pc); end
        end
        clear_inputs();
        pc_write = 1; alu_result = 32'h100;
        tick();
        clear_inputs();
    endtask

    task automatic test_ignored_ir_write();
        logic [31:0] d1, held;
        d1 = $urandom();
        ir_write = 1;
        tick();
        clear_inputs();
        mem_gnt = 1;
        tick();
        clear_inputs();
        ir_write = 1; pc_write = 1; alu_result = $urandom() & 32'hFFFF_FFFC;
        tick();
        clear_inputs();
        tick();
        mem_rvalid = 1; mem_rdata = d1;
        tick();
        clear_inputs();
        checks++; if (instr !== d1 || instr_valid !== 1'b1) begin errors++; $display("FAIL ign_capture: got %h v=%b expected %h/1", instr, instr_valid, d1); end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (mem_req !== 1'b0 || fetch_busy !== 1'b0) begin errors++; $display("FAIL ign_no_req %0d: got req=%b busy=%b expected 0/0", c, mem_req, fetch_busy); end
        end
        checks++; if (instr !== d1) begin errors++; $display("FAIL ign_ir_hold: got %h expected %h", instr, d1); end
        held = pc;
        pc_source = 2'b11; pc_write = 1; alu_result = $urandom();
        tick();
        clear_inputs();
        checks++; if (pc !== held || pc !== m_pc) begin errors++; $display("FAIL pcsrc_hold: got %h expected %h", pc, m_pc); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++) begin
            logic [31:0] d;
            d = $urandom();
            ir_write = 1; pc_write = 1; alu_result = $urandom() & 32'hFFFF_FFFC;
            tick();
            clear_inputs();
            checks++; if (mem_req !== 1'b1 || mem_addr !== m_addr) begin errors++; $display("FAIL b2b_req %0d: got req=%b addr=%h expected 1/%h", k, mem_req, mem_addr, m_addr); end
            mem_gnt = 1; mem_rvalid = 1; mem_rdata = d;
            tick();
            clear_inputs();
            checks++; if (instr !== d || instr_valid !== 1'b1) begin errors++; $display("FAIL b2b_data %0d: got %h v=%b expected %h/1", k, instr, instr_valid, d); end
        end
        tick();
    endtask

    task automatic test_reset_mid_fetch();
        ir_write = 1;
        tick();
        clear_inputs();
        mem_gnt = 1;
        tick();
        clear_inputs();
        tick();
        rst = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0 || fetch_busy !== 1'b0 || instr !== 32'h0) begin errors++; $display("FAIL rst_async: got req=%b busy=%b instr=%h expected 0/0/0", mem_req, fetch_busy, instr); end
        do_reset();
        mem_rvalid = 1; mem_rdata = $urandom() | 32'h1;
        tick();
        clear_inputs();
        checks++; if (instr !== 32'h0 || instr_valid !== 1'b0 || fetch_busy !== 1'b0) begin errors++; $display("FAIL rst_late_rvalid: got instr=%h v=%b busy=%b expected 0/0/0", instr, instr_valid, fetch_busy); end
        tick();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_no_valid: got %b expected 0", instr_valid); end
        pc_write = 1; alu_result = 32'h2;
        tick();
        clear_inputs();
        ir_write = 1;
        tick();
        clear_inputs();
        checks++; if (fetch_err !== 1'b1 || mem_req !== 1'b0 || fetch_err !== m_err) begin errors++; $display("FAIL misaligned: got err=%b req=%b expected 1/0", fetch_err, mem_req); end
        checks++; if (pc !== 32'h2) begin errors++; $display("FAIL misaligned_pc: got %h expected 2", pc); end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_basic_fetch();
        test_wait_states();
        test_timeout();
        test_pc_update();
        test_ignored_ir_write();
        test_back_to_back();
        test_reset_mid_fetch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
